// File: rtl/vco_band_cal.sv
`default_nettype none
// ============================================================================
// Module      : vco_band_cal
// Description : Successive-approximation VCO band calibrator with post-search
//               verification; VCO_CAL_TRACK_EN adds post-lock drift tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module vco_band_cal #(
    parameter int unsigned TUNE_W     = 5,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned REF_WIN    = 256,
    parameter int unsigned SETTLE_CYC = 32,
    parameter int unsigned TOL        = 2,
    parameter int unsigned TUNE_RST   = (1 << (TUNE_W - 1)) - 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              start,
    input  logic              vco_tick,
    input  logic [CNT_W-1:0]  target,
    output logic [TUNE_W-1:0] tune,
    output logic              busy,
    output logic              done,
    output logic              cal_err,
    output logic [CNT_W-1:0]  meas_cnt
);

    localparam int unsigned c_CYC_MAX = (SETTLE_CYC > REF_WIN) ? SETTLE_CYC : REF_WIN;
    localparam int unsigned c_CYC_W   = $clog2(c_CYC_MAX + 1);
    localparam int unsigned c_IDX_W   = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;

    localparam logic [c_CYC_W-1:0] c_SETTLE_LAST = c_CYC_W'(SETTLE_CYC - 1);
    localparam logic [c_CYC_W-1:0] c_WIN_LAST    = c_CYC_W'(REF_WIN - 1);
    localparam logic [TUNE_W-1:0]  c_TUNE_RST    = TUNE_W'(TUNE_RST);
    localparam logic [TUNE_W-1:0]  c_TUNE_INIT   = TUNE_W'(1) << (TUNE_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_INIT    = c_IDX_W'(TUNE_W - 1);
    localparam logic [CNT_W-1:0]   c_TOL         = CNT_W'(TOL);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SETTLE   = 4'd1,
        S_MEASURE  = 4'd2,
        S_DECIDE   = 4'd3,
        S_VSETTLE  = 4'd4,
        S_VMEASURE = 4'd5,
        S_DONE     = 4'd6
`ifdef VCO_CAL_TRACK_EN
        ,
        S_TSETTLE  = 4'd7,
        S_TMEASURE = 4'd8
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0]   r_tick;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_meas;
    logic [TUNE_W-1:0]  r_tune;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_cal_err;

    logic [CNT_W-1:0]   w_tick_nxt;
    logic [CNT_W-1:0]   w_diff;
    logic               w_over;
    logic               w_settle_end;
    logic               w_win_end;
    logic               w_in_settle;
    logic               w_in_meas;
    logic               w_in_track;
    logic               w_start_ok;
    logic [TUNE_W-1:0]  w_tune_dec;

    assign w_settle_end = (r_cyc == c_SETTLE_LAST);
    assign w_win_end    = (r_cyc == c_WIN_LAST);
    // Saturating tick count including the current cycle's tick.
    assign w_tick_nxt   = (vco_tick && (r_tick != '1)) ? r_tick + 1'b1 : r_tick;
    assign w_diff       = (w_tick_nxt > r_target) ? (w_tick_nxt - r_target)
                                                  : (r_target - w_tick_nxt);
    assign w_over       = (w_diff > c_TOL);

`ifdef VCO_CAL_TRACK_EN
    assign w_in_track  = (r_state == S_TSETTLE) || (r_state == S_TMEASURE);
    assign w_in_settle = (r_state == S_SETTLE) || (r_state == S_VSETTLE) || (r_state == S_TSETTLE);
    assign w_in_meas   = (r_state == S_MEASURE) || (r_state == S_VMEASURE) || (r_state == S_TMEASURE);
`else
    assign w_in_track  = 1'b0;
    assign w_in_settle = (r_state == S_SETTLE) || (r_state == S_VSETTLE);
    assign w_in_meas   = (r_state == S_MEASURE) || (r_state == S_VMEASURE);
`endif

    assign w_start_ok = start && ((r_state == S_IDLE) || w_in_track);

    always_comb begin
        w_tune_dec = r_tune;
        if (r_meas > r_target) begin
            w_tune_dec[r_idx] = 1'b0;
        end
        if (r_idx != '0) begin
            w_tune_dec[r_idx - 1'b1] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_SETTLE;
            S_SETTLE:   if (w_settle_end) w_state_nxt = S_MEASURE;
            S_MEASURE:  if (w_win_end) w_state_nxt = S_DECIDE;
            S_DECIDE:   w_state_nxt = (r_idx == '0) ? S_VSETTLE : S_SETTLE;
            S_VSETTLE:  if (w_settle_end) w_state_nxt = S_VMEASURE;
            S_VMEASURE: if (w_win_end) w_state_nxt = S_DONE;
`ifdef VCO_CAL_TRACK_EN
            S_DONE:     w_state_nxt = S_TSETTLE;
            S_TSETTLE: begin
                if (start)             w_state_nxt = S_SETTLE;
                else if (w_settle_end) w_state_nxt = S_TMEASURE;
            end
            S_TMEASURE: begin
                if (start)          w_state_nxt = S_SETTLE;
                else if (w_win_end) w_state_nxt = S_TSETTLE;
            end
`else
            S_DONE:     w_state_nxt = S_IDLE;
`endif
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_cyc     <= '0;
            r_tick    <= '0;
            r_target  <= '0;
            r_meas    <= '0;
            r_tune    <= c_TUNE_RST;
            r_idx     <= '0;
            r_cal_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cyc <= '0;
            end else if (w_in_settle || w_in_meas) begin
                r_cyc <= r_cyc + 1'b1;
            end
            // Counter is held at zero outside a running window so each window starts clean.
            r_tick <= (w_in_meas && (w_state_nxt == r_state)) ? w_tick_nxt : '0;

            if (w_start_ok) begin
                r_target  <= target;
                r_cal_err <= 1'b0;
                r_idx     <= c_IDX_INIT;
                r_tune    <= c_TUNE_INIT;
            end else begin
                case (r_state)
                    S_MEASURE: begin
                        if (w_win_end) r_meas <= w_tick_nxt;
                    end
                    S_DECIDE: begin
                        r_tune <= w_tune_dec;
                        if (r_idx != '0) r_idx <= r_idx - 1'b1;
                    end
                    S_VMEASURE: begin
                        if (w_win_end) begin
                            r_meas    <= w_tick_nxt;
                            r_cal_err <= w_over;
                        end
                    end
`ifdef VCO_CAL_TRACK_EN
                    S_TMEASURE: begin
                        if (w_win_end) begin
                            r_meas    <= w_tick_nxt;
                            r_cal_err <= 1'b0;
                            if (w_over && (w_tick_nxt > r_target)) begin
                                if (r_tune == '0) r_cal_err <= 1'b1;
                                else              r_tune    <= r_tune - 1'b1;
                            end else if (w_over) begin
                                if (r_tune == '1) r_cal_err <= 1'b1;
                                else              r_tune    <= r_tune + 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign tune     = r_tune;
    assign busy     = (r_state != S_IDLE) && !w_in_track;
    assign done     = (r_state == S_DONE);
    assign cal_err  = r_cal_err;
    assign meas_cnt = r_meas;

endmodule
`default_nettype wire

// File: doc/vco_band_cal.md
# vco_band_cal

Successive-approximation band calibrator for the CDR/PLL VCO. It selects the VCO `tune` code that makes the measured VCO frequency match a programmed target count. Frequency is measured as the number of `vco_tick` pulses seen in a fixed `refclk` window. The block generalises the fixed 5-bit `tune` bus to a parametrised width, runs a post-search verification measurement, and can optionally keep tracking drift after lock.

## Interface
- `TUNE_W`, 5: width of the tune code (VCO bands = 2^TUNE_W).
- `CNT_W`, 12: width of the tick counter and the target.
- `REF_WIN`, 256: `refclk` cycles per measurement window (≥1, < 2^CNT_W).
- `SETTLE_CYC`, 32: `refclk` cycles waited after every tune change (≥1).
- `TOL`, 2: allowed |count − target| at verification/tracking.
- `TUNE_RST`, 2^(TUNE_W−1)−1: tune value at reset (5'b01111 at default width).

Ports:
- `refclk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin calibration.
- `vco_tick`  in  1  one-cycle pulse per prescaled VCO period, already synchronous to `refclk`.
- `target`  in  CNT_W  desired tick count per window; sampled on accepted `start`.
- `tune`  out  TUNE_W  band code driven to the VCO.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when calibration completes.
- `cal_err`  out  1  verification error > TOL; held until the next accepted `start` or `rst`.
- `meas_cnt`  out  CNT_W  count from the last completed window.

## Operation
- States: IDLE, SETTLE, MEASURE, DECIDE, VERIFY_SETTLE, VERIFY_MEASURE, DONE.
- IDLE: `start` is accepted here only; it latches `target`, clears `cal_err`, sets bit index i = TUNE_W−1, loads `tune` = 1<<i, and moves to SETTLE.
- SETTLE: counts SETTLE_CYC cycles, then moves to MEASURE with the tick counter at 0.
- MEASURE: counts `vco_tick` over exactly REF_WIN cycles. The counter saturates at 2^CNT_W−1. At the end it loads `meas_cnt` and moves to DECIDE.
- DECIDE (1 cycle): if `meas_cnt` > target, clear bit i; equality keeps the bit. Tune is assumed monotonic increasing in frequency.
  - If i > 0: i−1, set bit i−1, go to SETTLE.
  - If i = 0: go to VERIFY_SETTLE, with `tune` holding the final code.
- VERIFY_SETTLE / VERIFY_MEASURE: same lengths as SETTLE / MEASURE, at the final code. At the end, load `meas_cnt`, set `cal_err` = (|meas_cnt − target| > TOL), and go to DONE.
- DONE (1 cycle): assert `done`, go to IDLE. `tune` holds.
- `start` while busy or in DONE is ignored.
- `rst` wins over `start` in the same cycle.
- `rst` mid-operation aborts to IDLE with reset values.

## Timing
- Reset values: `tune` = TUNE_RST, `busy` = 0, `done` = 0, `cal_err` = 0, `meas_cnt` = 0, state IDLE.
- Each step (search or verify) lasts S = SETTLE_CYC + REF_WIN cycles, plus 1 DECIDE cycle for search steps.
- The `start` cycle is cycle 0. `done` is high in cycle 1 + TUNE_W·(S+1) + S.
- `tune` changes only on the cycle entering SETTLE, so the VCO always sees a full SETTLE_CYC before counting starts.
- `vco_tick` in a MEASURE cycle is counted. Ticks in SETTLE/DECIDE are not.
- `meas_cnt` and `cal_err` update on the last MEASURE-type cycle's edge.

## Configuration
- Macro `VCO_CAL_TRACK_EN`.
- Defined: DONE enters a TRACK loop instead of IDLE. The loop repeats SETTLE_CYC + REF_WIN windows; `busy` is low and `done` does not pulse again. After each window, `meas_cnt` updates:
  - count > target+TOL: `tune` −1, saturating at 0.
  - count < target−TOL: `tune` +1, saturating at 2^TUNE_W−1.
  - `cal_err` = 1 while `tune` is saturated and the error is still > TOL.
  - `start` in TRACK restarts full calibration as from IDLE.
- Undefined: no TRACK state; behaviour is exactly as above.

## Test plan
Bench setup: TUNE_W=5, REF_WIN=16, SETTLE_CYC=4, TOL=0, VCO model ticks 2·tune per window.
- target=30, start → codes 16, 8, 12, 14, 15; final `tune`=15, `meas_cnt`=30, `cal_err`=0, `done` at cycle 1+5·21+20=126.
- target=63 → `tune`=31, `meas_cnt`=62, `cal_err`=1.
- target=0 → `tune`=0, `cal_err`=0.
- `rst` asserted in the 3rd search step → next cycle `tune`=15, `busy`=0, no `done`. A start pulse while busy is ignored.
- Reset followed by start in the same cycle → stays IDLE.
- `VCO_CAL_TRACK_EN`: calibrate to 30, then shift the model to 2·tune+4 → `tune` steps 15→14→13 over two windows, then holds at `meas_cnt`=30.
